// File: rtl/lock_pkg.sv
// Shared definitions for the code-lock datapath: digit limits, entry limits and
// the debounce FSM encoding used by the digit entry front end.
package lock_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
  localparam logic [2:0] ENTRY_MAX = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } de_state_t;

  function automatic logic digit_is_err(input logic [DIGIT_W-1:0] d);
    return (d > DIGIT_MAX);
  endfunction

  // Entry counter stops at ENTRY_MAX so the lock sees a stable "full" count.
  function automatic logic [2:0] entry_inc(input logic [2:0] c);
    return (c >= ENTRY_MAX) ? ENTRY_MAX : c + 3'd1;
  endfunction

endpackage

// File: rtl/digit_entry_frontend_if.sv
// Signal bundle between the board-facing inputs and the lock FSM side.
interface digit_entry_frontend_if;
  import lock_pkg::*;

  logic               key_n;
  logic [DIGIT_W-1:0] sw_in;
  logic               digit_valid;
  logic [DIGIT_W-1:0] digit;
  logic               digit_err;
  logic               key_pressed;
  logic [2:0]         entry_cnt;

  modport master (
    output key_n, sw_in,
    input  digit_valid, digit, digit_err, key_pressed, entry_cnt
  );

  modport slave (
    input  key_n, sw_in,
    output digit_valid, digit, digit_err, key_pressed, entry_cnt
  );

endinterface

// File: rtl/digit_entry_frontend_sync_2ff.sv
// Two-flop synchroniser with a configurable reset value, for async board inputs.
module sync_2ff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/digit_entry_frontend.sv
// Debounced "enter" button front end: one digit_valid strobe per physical press,
// carrying the synchronised switch value, an error flag and a saturating count.
module digit_entry_frontend
  import lock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  digit_entry_frontend_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               w_key_sync;
  logic [DIGIT_W-1:0] w_sw_sync;

  de_state_t          r_state;
  de_state_t          w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_accept;

  logic               r_digit_valid;
  logic [DIGIT_W-1:0] r_digit;
  logic               r_digit_err;
  logic [2:0]         r_entry_cnt;

  // Key synchroniser resets to "released" so reset never looks like a press.
  sync_2ff #(.W(1), .RST_VAL(1'b1)) u_sync_key (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.key_n),
    .o_q   (w_key_sync)
  );

  sync_2ff #(.W(DIGIT_W), .RST_VAL('0)) u_sync_sw (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.sw_in),
    .o_q   (w_sw_sync)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_key_sync) begin
          w_state_nxt = ST_PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (w_key_sync) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_PRESSED;
          w_accept    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (w_key_sync) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (!w_key_sync) begin
          w_state_nxt = ST_PRESSED;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Capture happens only on acceptance, so switch changes while held are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_digit_valid <= 1'b0;
      r_digit       <= '0;
      r_digit_err   <= 1'b0;
      r_entry_cnt   <= '0;
    end else begin
      r_digit_valid <= w_accept;
      if (w_accept) begin
        r_digit     <= w_sw_sync;
        r_digit_err <= digit_is_err(w_sw_sync);
        r_entry_cnt <= entry_inc(r_entry_cnt);
      end
    end
  end

  assign bus.digit_valid = r_digit_valid;
  assign bus.digit       = r_digit;
  assign bus.digit_err   = r_digit_err;
  assign bus.entry_cnt   = r_entry_cnt;
  assign bus.key_pressed = (r_state == ST_PRESSED) || (r_state == ST_RELEASE_WAIT);

endmodule

// File: tb/tb_digit_entry_frontend.sv
// Directed bench for digit_entry_frontend with a short debounce window.
module tb_digit_entry_frontend;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   n_pulse;
  int   n0;

  digit_entry_frontend_if bus ();

  digit_entry_frontend #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n negedges; outputs are sampled there and strobes are tallied.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.digit_valid === 1'b1) n_pulse++;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    n_pulse = 0;
    reset   = 1'b1;
    bus.key_n = 1'b1;
    bus.sw_in = 4'd0;
    cyc(3);
    check("rst_valid", {7'd0, bus.digit_valid}, 8'd0);
    check("rst_digit", {4'd0, bus.digit}, 8'd0);
    check("rst_err", {7'd0, bus.digit_err}, 8'd0);
    check("rst_kp", {7'd0, bus.key_pressed}, 8'd0);
    check("rst_cnt", {5'd0, bus.entry_cnt}, 8'd0);
    reset = 1'b0;
    cyc(3);

    // Clean press with digit 5, held 20 cycles
    n0 = n_pulse;
    bus.sw_in = 4'd5;
    bus.key_n = 1'b0;
    cyc(6);
    check("clean_early", {7'd0, bus.digit_valid}, 8'd0);
    cyc(1);
    check("clean_valid", {7'd0, bus.digit_valid}, 8'd1);
    check("clean_digit", {4'd0, bus.digit}, 8'd5);
    check("clean_err", {7'd0, bus.digit_err}, 8'd0);
    check("clean_cnt", {5'd0, bus.entry_cnt}, 8'd1);
    check("clean_kp", {7'd0, bus.key_pressed}, 8'd1);
    cyc(1);
    check("clean_one_cycle", {7'd0, bus.digit_valid}, 8'd0);
    cyc(12);
    bus.key_n = 1'b1;
    cyc(6);
    check("clean_kp_held", {7'd0, bus.key_pressed}, 8'd1);
    cyc(1);
    check("clean_kp_rel", {7'd0, bus.key_pressed}, 8'd0);
    cyc(4);
    check("clean_pulses", 8'(n_pulse - n0), 8'd1);

    // Press bounce: low 2, high 1, then low and held
    n0 = n_pulse;
    bus.sw_in = 4'd3;
    bus.key_n = 1'b0;
    cyc(2);
    bus.key_n = 1'b1;
    cyc(1);
    bus.key_n = 1'b0;
    cyc(6);
    check("bounce_early", {7'd0, bus.digit_valid}, 8'd0);
    cyc(1);
    check("bounce_valid", {7'd0, bus.digit_valid}, 8'd1);
    check("bounce_digit", {4'd0, bus.digit}, 8'd3);
    check("bounce_cnt", {5'd0, bus.entry_cnt}, 8'd2);
    cyc(3);
    bus.key_n = 1'b1;
    cyc(10);
    check("bounce_pulses", 8'(n_pulse - n0), 8'd1);

    // Three-cycle glitch must not be accepted
    n0 = n_pulse;
    bus.key_n = 1'b0;
    cyc(3);
    bus.key_n = 1'b1;
    cyc(10);
    check("glitch_pulses", 8'(n_pulse - n0), 8'd0);
    check("glitch_kp", {7'd0, bus.key_pressed}, 8'd0);
    check("glitch_cnt", {5'd0, bus.entry_cnt}, 8'd2);

    // Release bounce: high 2, low 2, then high
    bus.sw_in = 4'd7;
    bus.key_n = 1'b0;
    cyc(7);
    check("relb_valid", {7'd0, bus.digit_valid}, 8'd1);
    check("relb_cnt", {5'd0, bus.entry_cnt}, 8'd3);
    cyc(3);
    n0 = n_pulse;
    bus.key_n = 1'b1;
    cyc(2);
    bus.key_n = 1'b0;
    cyc(2);
    check("relb_kp_mid", {7'd0, bus.key_pressed}, 8'd1);
    bus.key_n = 1'b1;
    cyc(6);
    check("relb_kp_held", {7'd0, bus.key_pressed}, 8'd1);
    cyc(1);
    check("relb_kp_rel", {7'd0, bus.key_pressed}, 8'd0);
    cyc(3);
    check("relb_pulses", 8'(n_pulse - n0), 8'd0);

    // Out-of-range digit still strobes and counts
    bus.sw_in = 4'd12;
    bus.key_n = 1'b0;
    cyc(7);
    check("err_valid", {7'd0, bus.digit_valid}, 8'd1);
    check("err_digit", {4'd0, bus.digit}, 8'd12);
    check("err_flag", {7'd0, bus.digit_err}, 8'd1);
    check("err_cnt", {5'd0, bus.entry_cnt}, 8'd4);
    cyc(3);
    bus.key_n = 1'b1;
    cyc(10);
    check("err_flag_held", {7'd0, bus.digit_err}, 8'd1);

    // Saturation from a fresh reset: eight presses, count stops at 6
    reset = 1'b1;
    cyc(2);
    check("sat_rst_cnt", {5'd0, bus.entry_cnt}, 8'd0);
    reset = 1'b0;
    cyc(2);
    n0 = n_pulse;
    for (int i = 0; i < 8; i++) begin
      bus.sw_in = 4'(i);
      bus.key_n = 1'b0;
      cyc(7);
      check("sat_valid", {7'd0, bus.digit_valid}, 8'd1);
      check("sat_digit", {4'd0, bus.digit}, 8'(i));
      check("sat_cnt", {5'd0, bus.entry_cnt}, (i < 6) ? 8'(i + 1) : 8'd6);
      cyc(2);
      bus.key_n = 1'b1;
      cyc(8);
    end
    check("sat_pulses", 8'(n_pulse - n0), 8'd8);

    // Reset in PRESS_WAIT with cnt = 2, key kept low through release
    n0 = n_pulse;
    bus.sw_in = 4'd9;
    bus.key_n = 1'b0;
    cyc(5);
    reset = 1'b1;
    cyc(1);
    check("mid_rst_valid", {7'd0, bus.digit_valid}, 8'd0);
    check("mid_rst_digit", {4'd0, bus.digit}, 8'd0);
    check("mid_rst_kp", {7'd0, bus.key_pressed}, 8'd0);
    check("mid_rst_cnt", {5'd0, bus.entry_cnt}, 8'd0);
    reset = 1'b0;
    cyc(6);
    check("mid_rel_early", {7'd0, bus.digit_valid}, 8'd0);
    cyc(1);
    check("mid_rel_valid", {7'd0, bus.digit_valid}, 8'd1);
    check("mid_rel_digit", {4'd0, bus.digit}, 8'd9);
    check("mid_rel_err", {7'd0, bus.digit_err}, 8'd0);
    check("mid_rel_cnt", {5'd0, bus.entry_cnt}, 8'd1);
    cyc(2);
    bus.key_n = 1'b1;
    cyc(10);
    check("mid_pulses", 8'(n_pulse - n0), 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/digit_entry_frontend.md
Name: digit_entry_frontend

Overview:
- Input stage that sits directly upstream of the code-lock state machine on the DE1-SoC.
- Runs on the free-running board clock and synchronises the raw active-low "enter" pushbutton and the 4 digit switches.
- Debounces the button and emits exactly one single-cycle digit_valid strobe per physical press, carrying a captured digit and an error flag.
- The lock FSM advances only on digit_valid, not on a raw key edge.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable cycles that qualify a press or release (20 ms at 50 MHz). Minimum legal value is 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), localparam; width of the debounce counter.

Ports:
- clk  input  1  board clock.
- reset  input  1  synchronous, active-high.
- key_n  input  1  raw enter button, active-low, asynchronous to clk.
- sw_in  input  4  raw digit switches, asynchronous to clk.
- digit_valid  output  1  one-cycle strobe: a debounced press was accepted.
- digit  output  4  switch value captured with the strobe; held until the next strobe.
- digit_err  output  1  set when the captured digit is greater than 9; held with digit.
- key_pressed  output  1  debounced button level (1 = pressed).
- entry_cnt  output  3  number of accepted strobes since reset; saturates at 6.

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values:
  - digit_valid = 0, digit = 0, digit_err = 0, key_pressed = 0, entry_cnt = 0.
  - FSM = IDLE, counter = 0.
  - Synchroniser flops: key stage = 1 (released), sw stages = 0.
- Synchronisation: key_n and sw_in each pass through 2 flops, giving key_sync and sw_sync. No logic reads the raw inputs.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- IDLE:
  - key_sync = 0 -> PRESS_WAIT, cnt = 0.
- PRESS_WAIT:
  - key_sync = 1 -> IDLE (bounce rejected; no strobe).
  - Otherwise, if cnt = DEBOUNCE_CYCLES-1 -> PRESSED, and on that same edge: digit_valid <= 1, digit <= sw_sync, digit_err <= (sw_sync > 9).
  - Otherwise cnt++.
- PRESSED:
  - key_sync = 1 -> RELEASE_WAIT, cnt = 0.
- RELEASE_WAIT:
  - key_sync = 0 -> PRESSED (release bounce; no new strobe).
  - Otherwise, if cnt = DEBOUNCE_CYCLES-1 -> IDLE.
  - Otherwise cnt++.
- key_pressed = 1 in PRESSED and RELEASE_WAIT, 0 otherwise (registered / decoded from state).
- digit_valid is high for exactly one cycle and is cleared on the following edge unconditionally.
- Latency: key_n first sampled low at edge N and held low -> digit_valid high in the cycle after edge N+DEBOUNCE_CYCLES+2.
- entry_cnt:
  - Increments on the same edge digit_valid is set, saturating at 6 (a 7th press leaves it at 6).
  - Erroneous digits still count.
- digit_err does not suppress digit_valid; the downstream lock decides how to handle errors.
- Switch changes while the key is held are ignored until the next accepted press.
- Reset mid-debounce or mid-press: everything returns to reset values on that edge, with no strobe.
- Key held low through reset release: treated as a fresh press; a strobe appears DEBOUNCE_CYCLES+3 edges after reset deasserts.
- reset has priority over every other event on the same edge.

Decomposition:
- Shared package lock_pkg:
  - FSM state encodings for this block (2-bit).
  - DIGIT_W = 4, DIGIT_MAX = 9, ENTRY_MAX = 6.
  - The lock FSM imports the same DIGIT_MAX and ENTRY_MAX.
- One sub-module, sync_2ff:
  - Parameterised width and reset value.
  - Instantiated once for key_n (reset value 1) and once for sw_in (reset value 0).

Test Plan (DEBOUNCE_CYCLES = 4):
- Clean press: sw_in = 5, key_n low at edge 10 and held 20 cycles -> single digit_valid pulse in the cycle after edge 16; digit = 5, digit_err = 0, entry_cnt = 1. No second pulse on release.
- Bounce rejection: key_n low for 2 cycles, high for 1, then low and held -> only one pulse, at 6 edges after the final low sample. A 3-cycle-only glitch gives no pulse.
- Release bounce: after an accepted press, key_n high 2 cycles, low 2, then high -> no extra pulse; key_pressed stays 1 until 4 stable high cycles have elapsed.
- Error digit: sw_in = 12 (4'b1100) with a valid press -> digit_valid = 1, digit = 12, digit_err = 1, entry_cnt increments.
- Saturation: 8 clean presses with sw_in = 0,1,...,7 -> 8 strobes; entry_cnt reads 1..6 and then holds at 6; digit follows each capture.
- Reset mid-operation: reset asserted in PRESS_WAIT with cnt = 2 -> no strobe; all outputs 0 next cycle. With key held through reset release -> one strobe 7 edges after reset deasserts.
